// File: rtl/isa_pkg.sv
// Shared ISA definitions for the model computer: instruction classes, opcode
// field positions and the encoder FSM state enum (also imported by the decoder).
package isa_pkg;

  localparam logic [1:0] CLS_IMM  = 2'b00;
  localparam logic [1:0] CLS_CALC = 2'b01;
  localparam logic [1:0] CLS_COPY = 2'b10;
  localparam logic [1:0] CLS_COND = 2'b11;

  // Opcode layout: [7:6] class, [5:3] copy source, [2:0] a/dest, [5:0] immediate
  localparam int OPC_CLS_LSB = 6;
  localparam int OPC_SRC_LSB = 3;
  localparam int OPC_DST_LSB = 0;
  localparam int OPC_IMM_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

endpackage

// File: rtl/opcode_encoder_if.sv
// Handshake bundles around the encoder: decoded-field input stream and
// program-memory write stream. Master drives valid/data, slave drives ready.
interface opcode_fld_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_class;
  logic [2:0] in_a;
  logic [2:0] in_b;
  logic [5:0] in_imm;
  logic       in_last;

  modport master (output in_valid, in_class, in_a, in_b, in_imm, in_last,
                  input  in_ready);
  modport slave  (input  in_valid, in_class, in_a, in_b, in_imm, in_last,
                  output in_ready);
endinterface

interface opcode_wr_if #(parameter int ADDR_W = 8);
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_opcode;
  logic [ADDR_W-1:0] out_addr;

  modport master (output out_valid, out_opcode, out_addr,
                  input  out_ready);
  modport slave  (input  out_valid, out_opcode, out_addr,
                  output out_ready);
endinterface

// File: rtl/opcode_pack.sv
// Combinational fields->opcode packer, zero latency, no flow control.
// Fields a class does not use never reach the opcode.
module opcode_pack
  import isa_pkg::*;
(
  input  logic [1:0] cls_i,
  input  logic [2:0] a_i,
  input  logic [2:0] b_i,
  input  logic [5:0] imm_i,
  output logic [7:0] opcode_o
);

  always_comb begin
    opcode_o = 8'h00;
    case (cls_i)
      CLS_IMM:  opcode_o = {CLS_IMM,  imm_i};
      CLS_CALC: opcode_o = {CLS_CALC, 3'b000, a_i};
      CLS_COPY: opcode_o = {CLS_COPY, a_i, b_i};
      default:  opcode_o = {CLS_COND, 3'b000, a_i};
    endcase
  end

endmodule

// File: rtl/opcode_encoder.sv
// Streaming instruction encoder: accept at edge N gives out_valid at N+1, 1/cycle;
// one-deep output register stalls in_ready while full and out_ready is low. OPCODE_ENC_CHECKSUM_EN adds checksum.
module opcode_encoder
  import isa_pkg::*;
#(
  parameter int ADDR_W = 8
)
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  opcode_fld_if.slave     fld,
  opcode_wr_if.master     wr,
  output logic            busy,
  output logic            done,
  output logic            overflow,
  output logic [ADDR_W:0] count
`ifdef OPCODE_ENC_CHECKSUM_EN
  ,
  output logic [7:0]      checksum
`endif
);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              out_vld_q, out_vld_d;
  logic [7:0]        opc_q, opc_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic [7:0]        packed_opc;
  logic              in_rdy;
  logic              accept;
  logic              at_max;

  opcode_pack u_pack (
    .cls_i    (fld.in_class),
    .a_i      (fld.in_a),
    .b_i      (fld.in_b),
    .imm_i    (fld.in_imm),
    .opcode_o (packed_opc)
  );

  assign in_rdy = (state_q == ST_LOAD) && (!out_vld_q || wr.out_ready);
  assign accept = fld.in_valid && in_rdy;
  assign at_max = &addr_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    out_vld_d = out_vld_q;
    opc_d     = opc_q;
    oaddr_d   = oaddr_q;
    if (out_vld_q && wr.out_ready) begin
      out_vld_d = 1'b0;
    end
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          out_vld_d = 1'b1;
          opc_d     = packed_opc;
          oaddr_d   = addr_q;
          count_d   = count_q + 1'b1;
          // The last slot closes the program; the address holds instead of wrapping
          if (fld.in_last || at_max) begin
            state_d = ST_DONE;
            ovf_d   = !fld.in_last;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
      opc_q     <= 8'h00;
      oaddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      out_vld_q <= out_vld_d;
      opc_q     <= opc_d;
      oaddr_q   <= oaddr_d;
    end
  end

`ifdef OPCODE_ENC_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start && (state_q != ST_LOAD)) begin
      csum_d = 8'h00;
    end else if (accept) begin
      csum_d = csum_q ^ packed_opc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

  assign fld.in_ready  = in_rdy;
  assign wr.out_valid  = out_vld_q;
  assign wr.out_opcode = opc_q;
  assign wr.out_addr   = oaddr_q;
  assign busy          = (state_q == ST_LOAD);
  assign done          = (state_q == ST_DONE);
  assign overflow      = ovf_q;
  assign count         = count_q;

endmodule

// File: doc/opcode_encoder.md
# opcode_encoder

Streaming instruction encoder for the model computer: accepts decoded instruction fields (class plus operands) over a valid/ready handshake and emits packed 8-bit opcodes, each tagged with a sequential program-memory address. It is the inverse of the front-end opcode decoder. It sits between the program loader (host/test harness) and program-memory write port, framing one program per `start` … `in_last` sequence.

## Interface
- `ADDR_W`, 8: program-memory address width; depth = 2^ADDR_W.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle pulse; begins a new program.
- `in_valid`  in  1  input fields valid.
- `in_ready`  out  1  encoder can accept fields.
- `in_class`  in  2  00 immediate, 01 calculation, 10 copy, 11 condition.
- `in_a`  in  3  ALU op / copy source / condition code.
- `in_b`  in  3  copy destination.
- `in_imm`  in  6  immediate value.
- `in_last`  in  1  final instruction of the program.
- `out_valid`  out  1  opcode/address valid.
- `out_ready`  in  1  memory accepts write.
- `out_opcode`  out  8  encoded instruction.
- `out_addr`  out  ADDR_W  write address.
- `busy`  out  1  state == LOAD.
- `done`  out  1  program complete; held until next `start`.
- `overflow`  out  1  memory filled before `in_last`; held until next `start`.
- `count`  out  ADDR_W+1  instructions accepted this program.

## Operation
- Encoding (per class): 00 → {00, imm[5:0]}; 01 → {01, 000, a}; 10 → {10, a, b}; 11 → {11, 000, a}. Unused fields are ignored, never forced into the opcode.
- FSM states: IDLE (reset), LOAD, DONE.
  - IDLE/DONE + `start` → LOAD; clears addr counter, `count`, `done`, `overflow`.
  - `start` while in LOAD is ignored.
  - LOAD, accept with `in_last` → DONE, `done`=1.
  - LOAD, accept at addr = 2^ADDR_W−1 without `in_last` → DONE, `done`=1, `overflow`=1.
  - Accept at max addr with `in_last`: `done`=1, `overflow`=0.
- `in_ready` = LOAD && (!out_valid || out_ready). Accept = `in_valid && in_ready`.
- On accept: output register loads opcode and current addr; addr counter +1; `count` +1.
- Output stage is one register deep. `out_valid` holds and `out_opcode`/`out_addr` stay stable until `out_ready`. The final opcode may still be draining after the FSM enters DONE.
- Address never wraps within a program.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_opcode`=0, `out_addr`=0, `busy`=0, `done`=0, `overflow`=0, `count`=0; state IDLE.
- Latency: accept at edge N → `out_valid` at N+1. Throughput is 1/cycle with `out_ready` held high.
- `start` at edge N → `busy`=1, `in_ready` may be 1 after N.
- Simultaneous output drain and new accept in the same cycle is allowed (back-to-back).
- Asynchronous reset mid-program clears everything immediately and drops any pending output.

## Configuration
- `OPCODE_ENC_CHECKSUM_EN` defined: adds output `checksum[7:0]`. It is the XOR of all opcodes accepted since `start`, cleared on `start` and reset, and is valid when `done`=1.
- Undefined: no port, no logic.

## Structure
- Shared package `isa_pkg`: class encodings (`CLS_IMM`=2'b00, `CLS_CALC`=2'b01, `CLS_COPY`=2'b10, `CLS_COND`=2'b11), opcode field positions, state enum.
- The decoder imports the same class constants.
- One sub-module: `opcode_pack`, combinational fields→byte, reused by test benches as the golden encoder.

## Test plan
- Reset, `start`, then send imm=6'h2A, copy a=3 b=5, calc a=4, cond a=1 (last), `out_ready`=1 → opcodes 0x2A, 0x9D, 0x44, 0xC1 at addr 0..3; `done`=1, `count`=4.
- `out_ready` low 3 cycles with output pending → `in_ready`=0, `out_opcode`/`out_addr` stable. Release → stream resumes with no loss or duplication.
- ADDR_W=2, five instructions, no `in_last` → 4 written, `overflow`=1, `done`=1, fifth never accepted (`in_ready`=0).
- `start` pulsed mid-LOAD → ignored, address sequence continues. After DONE, `start` → addr restarts at 0, flags cleared.
- Assert `rst_n` low during LOAD with `out_valid`=1 → all outputs 0 immediately, state IDLE.
- With `OPCODE_ENC_CHECKSUM_EN`: first sequence gives `checksum` = 0x2A^0x9D^0x44^0xC1 = 0x32.
